// File: rtl/screen_line_fetcher_if.sv
// Fetch control, screen RAM read port and renderer pixel port of the line fetcher.
interface screen_line_fetcher_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned DATA_W = 8;

    logic              fetch_start;
    logic [ROW_W-1:0]  fetch_row;
    logic              busy;
    logic              done;
    logic              swap;
    logic              mem_read_en;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              pix_en;
    logic [ROW_W-1:0]  pix_x;
    logic [DATA_W-1:0] pix_data;
    logic              front_sel;

    modport master (
        output fetch_start, fetch_row, swap, mem_read_data, pix_en, pix_x,
        input  busy, done, mem_read_en, mem_read_addr, pix_data, front_sel
    );

    modport slave (
        input  fetch_start, fetch_row, swap, mem_read_data, pix_en, pix_x,
        output busy, done, mem_read_en, mem_read_addr, pix_data, front_sel
    );
endinterface

// File: rtl/screen_line_fetcher.sv
// Double-buffered line fetcher: copies one 32-pixel screen row from RAM into the
// back bank while the renderer reads the front bank.
module screen_line_fetcher #(
    parameter logic [10:0] BASE_ADDR = 11'h200
) (
    input logic                   clk,
    input logic                   reset,
    screen_line_fetcher_if.slave  bus
);
    localparam int unsigned ROW_PIXELS = 32;
    localparam int unsigned COL_W      = 5;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DATA_W     = 8;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [COL_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              tgt_bank;
    logic              wr_pending;
    logic [COL_W-1:0]  wr_idx;
    logic [DATA_W-1:0] bank0 [ROW_PIXELS];
    logic [DATA_W-1:0] bank1 [ROW_PIXELS];

    // Control FSM, bank select and renderer read port; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            row               <= '0;
            col               <= '0;
            tgt_bank          <= 1'b0;
            wr_pending        <= 1'b0;
            wr_idx            <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.mem_read_en   <= 1'b0;
            bus.mem_read_addr <= '0;
            bus.front_sel     <= 1'b0;
            bus.pix_data      <= '0;
        end else begin
            // RAM data for the read issued this cycle arrives next cycle.
            wr_pending <= bus.mem_read_en;
            wr_idx     <= col;

            if (bus.swap) begin
                bus.front_sel <= ~bus.front_sel;
            end
            if (bus.pix_en) begin
                bus.pix_data <= bus.front_sel ? bank1[bus.pix_x] : bank0[bus.pix_x];
            end

            case (state)
                IDLE: begin
                    if (bus.fetch_start) begin
                        state             <= READ;
                        row               <= bus.fetch_row;
                        col               <= '0;
                        tgt_bank          <= ~bus.front_sel;
                        bus.busy          <= 1'b1;
                        bus.mem_read_en   <= 1'b1;
                        bus.mem_read_addr <= BASE_ADDR + ADDR_W'({bus.fetch_row, COL_W'(0)});
                    end
                end
                READ: begin
                    col               <= col + COL_W'(1);
                    bus.mem_read_addr <= BASE_ADDR + ADDR_W'({row, COL_W'(col + COL_W'(1))});
                    if (col == LAST_COL) begin
                        state           <= DRAIN;
                        bus.mem_read_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    state    <= DONE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffer write port; a reset edge drops the pending write so an aborted
    // fetch leaves the remaining entries untouched.
    always_ff @(posedge clk) begin
        if (!reset && wr_pending) begin
            if (tgt_bank) begin
                bank1[wr_idx] <= bus.mem_read_data;
            end else begin
                bank0[wr_idx] <= bus.mem_read_data;
            end
        end
    end
endmodule

// File: tb/tb_screen_line_fetcher.sv
// Scoreboard bench for screen_line_fetcher: stimulus queues expected reads, done
// pulses and output values; a negedge monitor pops and compares them.
module tb_screen_line_fetcher;
    localparam int S_PIX   = 0;
    localparam int S_FRONT = 1;
    localparam int S_BUSY  = 2;
    localparam int S_DONE  = 3;
    localparam int S_EN    = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [10:0] val;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [10:0] addr;
    } rd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    screen_line_fetcher_if a();
    screen_line_fetcher_if b();

    screen_line_fetcher #(.BASE_ADDR(11'h200)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    screen_line_fetcher #(.BASE_ADDR(11'h7F0)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

    // Screen RAM models: data = low address byte, one cycle after the read.
    always @(posedge clk) begin
        if (a.mem_read_en) a.mem_read_data <= a.mem_read_addr[7:0];
        if (b.mem_read_en) b.mem_read_data <= b.mem_read_addr[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    rd_t  rd_a[$];
    rd_t  rd_b[$];
    int   done_a[$];
    int   done_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   fin = 1'b0;
    bit   fin_seen = 1'b0;
    int   run_a = 0;
    int   run_b = 0;
    exp_t m_e;
    rd_t  m_r;
    int   m_d;

    function automatic string sel_name(input int s);
        case (s)
            S_PIX:   return "pix_data";
            S_FRONT: return "front_sel";
            S_BUSY:  return "busy";
            S_DONE:  return "done";
            default: return "mem_read_en";
        endcase
    endfunction

    function automatic logic [10:0] sel_val(input int s);
        case (s)
            S_PIX:   return 11'(a.pix_data);
            S_FRONT: return 11'(a.front_sel);
            S_BUSY:  return 11'(a.busy);
            S_DONE:  return 11'(a.done);
            default: return 11'(a.mem_read_en);
        endcase
    endfunction

    // Monitor: all comparisons and counters live here.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            checks++;
            if (m_e.cyc != cyc || sel_val(m_e.sel) !== m_e.val) begin
                errors++;
                $display("FAIL %s @%0d: got %h, expected %h (due @%0d)",
                         sel_name(m_e.sel), cyc, sel_val(m_e.sel), m_e.val, m_e.cyc);
            end
        end

        while (rd_a.size() != 0 && rd_a[0].cyc < cyc) begin
            m_r = rd_a.pop_front();
            checks++; errors++;
            $display("FAIL a_read @%0d: got no read, expected addr %h", m_r.cyc, m_r.addr);
        end
        if (a.mem_read_en) begin
            checks++;
            if (rd_a.size() == 0) begin
                errors++;
                $display("FAIL a_read @%0d: got addr %h, expected no read", cyc, a.mem_read_addr);
            end else begin
                m_r = rd_a.pop_front();
                if (m_r.cyc != cyc || m_r.addr !== a.mem_read_addr) begin
                    errors++;
                    $display("FAIL a_read @%0d: got addr %h, expected addr %h @%0d",
                             cyc, a.mem_read_addr, m_r.addr, m_r.cyc);
                end
            end
        end

        while (rd_b.size() != 0 && rd_b[0].cyc < cyc) begin
            m_r = rd_b.pop_front();
            checks++; errors++;
            $display("FAIL b_read @%0d: got no read, expected addr %h", m_r.cyc, m_r.addr);
        end
        if (b.mem_read_en) begin
            checks++;
            if (rd_b.size() == 0) begin
                errors++;
                $display("FAIL b_read @%0d: got addr %h, expected no read", cyc, b.mem_read_addr);
            end else begin
                m_r = rd_b.pop_front();
                if (m_r.cyc != cyc || m_r.addr !== b.mem_read_addr) begin
                    errors++;
                    $display("FAIL b_read @%0d: got addr %h, expected addr %h @%0d",
                             cyc, b.mem_read_addr, m_r.addr, m_r.cyc);
                end
            end
        end

        if (a.busy) run_a++;
        else if (a.done) begin
            checks += 2;
            if (run_a != 33) begin
                errors++;
                $display("FAIL a_busy_len @%0d: got %0d cycles, expected 33", cyc, run_a);
            end
            m_d = (done_a.size() != 0) ? done_a.pop_front() : -1;
            if (m_d != cyc) begin
                errors++;
                $display("FAIL a_done @%0d: got pulse, expected pulse @%0d", cyc, m_d);
            end
            run_a = 0;
        end else run_a = 0;

        if (b.busy) run_b++;
        else if (b.done) begin
            checks += 2;
            if (run_b != 33) begin
                errors++;
                $display("FAIL b_busy_len @%0d: got %0d cycles, expected 33", cyc, run_b);
            end
            m_d = (done_b.size() != 0) ? done_b.pop_front() : -1;
            if (m_d != cyc) begin
                errors++;
                $display("FAIL b_done @%0d: got pulse, expected pulse @%0d", cyc, m_d);
            end
            run_b = 0;
        end else run_b = 0;

        if (fin && !fin_seen) begin
            fin_seen = 1'b1;
            checks++;
            if (exp_q.size() + rd_a.size() + rd_b.size() + done_a.size() + done_b.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d/%0d/%0d/%0d/%0d pending, expected 0",
                         exp_q.size(), rd_a.size(), rd_b.size(), done_a.size(), done_b.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [10:0] v);
        exp_t e;
        e.cyc = c; e.sel = s; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic queue_reads_a(input int c, input logic [10:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            rd_t r;
            r.cyc  = c + 1 + k;
            r.addr = start + 11'(k);
            rd_a.push_back(r);
        end
    endtask

    task automatic pix(input logic [4:0] x, input logic [7:0] v);
        expect_at(cyc + 1, S_PIX, 11'(v));
        a.pix_en = 1'b1; a.pix_x = x;
        step();
        a.pix_en = 1'b0;
    endtask

    task automatic do_swap(input logic f);
        expect_at(cyc + 1, S_FRONT, 11'(f));
        a.swap = 1'b1;
        step();
        a.swap = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        a.fetch_start = 1'b0; a.fetch_row = '0; a.swap = 1'b0; a.pix_en = 1'b0; a.pix_x = '0;
        b.fetch_start = 1'b0; b.fetch_row = '0; b.swap = 1'b0; b.pix_en = 1'b0; b.pix_x = '0;
        step(); step();
        reset = 1'b0;
        expect_at(cyc, S_BUSY, 11'd0);
        expect_at(cyc, S_DONE, 11'd0);
        expect_at(cyc, S_EN, 11'd0);
        expect_at(cyc, S_FRONT, 11'd0);
        expect_at(cyc, S_PIX, 11'd0);

        // Row 3 into bank 1 on dut_a; row 0 with wrapping base on dut_b.
        c = cyc;
        queue_reads_a(c, 11'h260, 32);
        for (int k = 0; k < 32; k++) begin
            rd_t r;
            r.cyc  = c + 1 + k;
            r.addr = 11'h7F0 + 11'(k);
            rd_b.push_back(r);
        end
        done_a.push_back(c + 34);
        done_b.push_back(c + 34);
        expect_at(c + 32, S_EN, 11'd1);
        expect_at(c + 33, S_EN, 11'd0);
        expect_at(c + 33, S_BUSY, 11'd1);
        expect_at(c + 34, S_BUSY, 11'd0);
        expect_at(c + 34, S_DONE, 11'd1);
        expect_at(c + 35, S_DONE, 11'd0);
        a.fetch_start = 1'b1; a.fetch_row = 5'd3;
        b.fetch_start = 1'b1; b.fetch_row = 5'd0;
        step();
        a.fetch_start = 1'b0; b.fetch_start = 1'b0;
        repeat (34) step();

        do_swap(1'b1);
        pix(5'd5, 8'h65);
        pix(5'd31, 8'h7F);
        pix(5'd0, 8'h60);
        expect_at(cyc + 1, S_PIX, 11'h060);
        a.pix_x = 5'd9;
        step();

        // fetch_start held 36 cycles: ignored while busy and in DONE, restarts in IDLE.
        c = cyc;
        queue_reads_a(c, 11'h220, 32);
        queue_reads_a(c + 35, 11'h220, 32);
        done_a.push_back(c + 34);
        done_a.push_back(c + 69);
        expect_at(c + 35, S_BUSY, 11'd0);
        expect_at(c + 36, S_BUSY, 11'd1);
        a.fetch_start = 1'b1; a.fetch_row = 5'd1;
        repeat (36) step();
        a.fetch_start = 1'b0;
        repeat (35) step();

        // Swap together with a pixel read: read uses the pre-swap front bank.
        expect_at(cyc + 1, S_PIX, 11'h065);
        expect_at(cyc + 1, S_FRONT, 11'd0);
        a.swap = 1'b1; a.pix_en = 1'b1; a.pix_x = 5'd5;
        step();
        a.swap = 1'b0; a.pix_en = 1'b0;
        pix(5'd7, 8'h27);

        // Row 5 into bank 1 with a swap in read cycle 10 and a colliding read.
        c = cyc;
        queue_reads_a(c, 11'h2A0, 32);
        done_a.push_back(c + 34);
        a.fetch_start = 1'b1; a.fetch_row = 5'd5;
        step();
        a.fetch_start = 1'b0;
        repeat (9) step();
        do_swap(1'b1);
        step();
        pix(5'd10, 8'h6A);
        repeat (22) step();
        pix(5'd2, 8'hA2);
        pix(5'd31, 8'hBF);
        pix(5'd10, 8'hAA);
        do_swap(1'b0);
        pix(5'd7, 8'h27);
        pix(5'd31, 8'h3F);
        do_swap(1'b1);

        // Row 7 into bank 0, reset in read cycle 15 together with swap and fetch_start.
        c = cyc;
        queue_reads_a(c, 11'h2E0, 15);
        a.fetch_start = 1'b1; a.fetch_row = 5'd7;
        step();
        a.fetch_start = 1'b0;
        repeat (14) step();
        reset = 1'b1; a.swap = 1'b1; a.fetch_start = 1'b1;
        expect_at(c + 16, S_PIX, 11'd0);
        expect_at(c + 16, S_FRONT, 11'd0);
        expect_at(c + 16, S_BUSY, 11'd0);
        expect_at(c + 16, S_DONE, 11'd0);
        expect_at(c + 16, S_EN, 11'd0);
        step();
        reset = 1'b0; a.swap = 1'b0; a.fetch_start = 1'b0;
        expect_at(cyc + 1, S_BUSY, 11'd0);
        pix(5'd12, 8'hEC);
        pix(5'd13, 8'h2D);
        repeat (40) step();

        fin = 1'b1;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
